// File: rtl/mc_ctrl.sv
// mc_ctrl -- multi-cycle control FSM for the MIPS datapath.
//
// Sequences one instruction through FETCH/DECODE/EXEC/MEM/WB, drives every
// datapath mux select and write strobe, handshakes with a variable-latency
// data memory and counts retired legal instructions.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      synchronous active-high; state -> FETCH, instr_cnt -> 0
//   op, funct  IR[31:26] / IR[5:0] from the IR register
//   zero       ALU A==B flag, meaningful in EXEC
//   dm_ready   data memory finishes the access this cycle (MEM only)
//   pc_we, ir_we, reg_we          PC / IR / GRF write enables
//   dm_req, dm_we                 data memory request / write
//   sel_a3     GRF write address: 00 rt, 01 rd, 10 $31
//   sel_wd     GRF write data: 00 ALU, 01 DM read data, 10 PC register
//   sel_alub   ALU B: 0 rt data, 1 extender
//   sel_npc    next PC: 00 PC+4, 01 branch, 10 jump, 11 rs data
//   alu_op     000 add, 001 sub, 010 or, 011 pass B
//   ext_op     00 zero-ext, 01 sign-ext, 10 imm<<16
//   state      current state encoding
//   illegal    one-cycle pulse in DECODE for an unsupported instruction
//   instr_cnt  retired legal instruction count (wraps)
module mc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        dm_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        reg_we,
  output logic        dm_req,
  output logic        dm_we,
  output logic [1:0]  sel_a3,
  output logic [1:0]  sel_wd,
  output logic        sel_alub,
  output logic [1:0]  sel_npc,
  output logic [2:0]  alu_op,
  output logic [1:0]  ext_op,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b011;

  state_t state_q;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw;
  logic is_beq, is_j, is_jal, is_rtype, legal;

  // Instruction class decode straight from the IR fields.
  assign is_addu  = (op == OP_RTYPE) && (funct == FN_ADDU);
  assign is_subu  = (op == OP_RTYPE) && (funct == FN_SUBU);
  assign is_jr    = (op == OP_RTYPE) && (funct == FN_JR);
  assign is_ori   = (op == OP_ORI);
  assign is_lui   = (op == OP_LUI);
  assign is_lw    = (op == OP_LW);
  assign is_sw    = (op == OP_SW);
  assign is_beq   = (op == OP_BEQ);
  assign is_j     = (op == OP_J);
  assign is_jal   = (op == OP_JAL);
  assign is_rtype = is_addu | is_subu;
  assign legal    = is_rtype | is_jr | is_ori | is_lui | is_lw | is_sw |
                    is_beq | is_j | is_jal;

  assign state = state_q;

  // Per-state decode of the registered state and the IR fields.
  always_comb begin
    pc_we    = 1'b0;
    ir_we    = 1'b0;
    reg_we   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    illegal  = 1'b0;
    sel_a3   = 2'b00;
    sel_wd   = 2'b00;
    sel_alub = 1'b0;
    sel_npc  = 2'b00;
    alu_op   = ALU_ADD;
    ext_op   = 2'b00;
    case (state_q)
      S_FETCH: begin
        ir_we = 1'b1;
        pc_we = 1'b1;
      end
      S_DECODE: illegal = ~legal;
      S_EXEC: begin
        if (is_rtype) begin
          alu_op = is_subu ? ALU_SUB : ALU_ADD;
        end else if (is_ori) begin
          sel_alub = 1'b1;
          alu_op   = ALU_OR;
        end else if (is_lui) begin
          sel_alub = 1'b1;
          ext_op   = 2'b10;
          alu_op   = ALU_PASS;
        end else if (is_lw || is_sw) begin
          sel_alub = 1'b1;
          ext_op   = 2'b01;
        end else if (is_beq) begin
          alu_op  = ALU_SUB;
          ext_op  = 2'b01;
          sel_npc = 2'b01;
          pc_we   = zero;
        end else if (is_j) begin
          pc_we   = 1'b1;
          sel_npc = 2'b10;
        end else if (is_jal) begin
          // The GRF sees the PC register before this edge updates it,
          // which already holds jal address + 4.
          pc_we   = 1'b1;
          sel_npc = 2'b10;
          reg_we  = 1'b1;
          sel_a3  = 2'b10;
          sel_wd  = 2'b10;
        end else if (is_jr) begin
          pc_we   = 1'b1;
          sel_npc = 2'b11;
        end
      end
      S_MEM: begin
        // Address path is held from EXEC for the whole memory residency.
        dm_req   = 1'b1;
        dm_we    = is_sw;
        sel_alub = 1'b1;
        ext_op   = 2'b01;
      end
      S_WB: begin
        reg_we = 1'b1;
        if (is_rtype) sel_a3 = 2'b01;
        if (is_lw)    sel_wd = 2'b01;
      end
      default: ;
    endcase
    // Reset overrides the strobes immediately so an in-flight memory
    // request is abandoned in the cycle reset appears.
    if (reset) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      reg_we  = 1'b0;
      dm_req  = 1'b0;
      dm_we   = 1'b0;
      illegal = 1'b0;
    end
  end

  // State sequencing and retirement counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instr_cnt <= 32'd0;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: state_q <= legal ? S_EXEC : S_FETCH;
        S_EXEC: begin
          if (is_rtype || is_ori || is_lui) begin
            state_q <= S_WB;
          end else if (is_lw || is_sw) begin
            state_q <= S_MEM;
          end else begin
            state_q <= S_FETCH;
            if (is_beq || is_j || is_jal || is_jr) instr_cnt <= instr_cnt + 32'd1;
          end
        end
        S_MEM: begin
          if (dm_ready) begin
            if (is_lw) begin
              state_q <= S_WB;
            end else begin
              state_q <= S_FETCH;
              if (is_sw) instr_cnt <= instr_cnt + 32'd1;
            end
          end
        end
        S_WB: begin
          state_q   <= S_FETCH;
          instr_cnt <= instr_cnt + 32'd1;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
